// File: rtl/lcd_rx_capture_if.sv
// lcd_rx_capture_if: video input pins plus pixel-write and geometry status bundle
interface lcd_rx_capture_if #(
    parameter int CNT_W  = 12,
    parameter int ADDR_W = 17
);
    logic              hs;
    logic              vs;
    logic              de;
    logic [7:0]        rgb_r;
    logic [7:0]        rgb_g;
    logic [7:0]        rgb_b;
    logic              pix_valid;
    logic [ADDR_W-1:0] pix_addr;
    logic [23:0]       pix_data;
    logic              pix_sof;
    logic [CNT_W-1:0]  act_width;
    logic [CNT_W-1:0]  act_height;
    logic [CNT_W-1:0]  h_total;
    logic              locked;
    logic              err_pulse;

    modport master (
        output hs, vs, de, rgb_r, rgb_g, rgb_b,
        input  pix_valid, pix_addr, pix_data, pix_sof, act_width, act_height, h_total, locked, err_pulse
    );

    modport slave (
        input  hs, vs, de, rgb_r, rgb_g, rgb_b,
        output pix_valid, pix_addr, pix_data, pix_sof, act_width, act_height, h_total, locked, err_pulse
    );
endinterface

// File: rtl/lcd_rx_capture.sv
// lcd_rx_capture: measures incoming RGB video geometry, locks on two agreeing frames, emits addressed pixel writes
module lcd_rx_capture #(
    parameter bit HS_POL = 1'b0,
    parameter bit VS_POL = 1'b0,
    parameter int CNT_W  = 12,
    parameter int ADDR_W = 17
) (
    input logic            clk,
    input logic            rst,
    lcd_rx_capture_if.slave bus
);
    typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_t;

    localparam logic [CNT_W-1:0]  CMAX = '1;
    localparam logic [ADDR_W-1:0] AMAX = '1;

    logic              hs_q, vs_q, de_q, hs_p, vs_p, de_p;
    logic [23:0]       rgb_q;
    logic              fs, ls, le;
    logic [CNT_W-1:0]  line_cnt, frame_w, frame_h, hcnt, cand_w, cand_h;
    logic              frame_bad;
    state_t            state, state_n;
    logic              valid, match, err_n, take_cand, take_act;
    logic              frame_en, en, full, full_eff, wr;
    logic [ADDR_W-1:0] nxt, nxt_eff;

    always_ff @(posedge clk) begin
        if (rst) begin
            {hs_q, vs_q, de_q, hs_p, vs_p, de_p} <= '0;
            rgb_q <= '0;
        end else begin
            hs_q  <= bus.hs == HS_POL;
            vs_q  <= bus.vs == VS_POL;
            de_q  <= bus.de;
            rgb_q <= {bus.rgb_r, bus.rgb_g, bus.rgb_b};
            hs_p  <= hs_q;
            vs_p  <= vs_q;
            de_p  <= de_q;
        end
    end

    assign fs = vs_q & ~vs_p;
    assign ls = hs_q & ~hs_p;
    assign le = de_p & ~de_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            line_cnt    <= '0;
            frame_w     <= '0;
            frame_h     <= '0;
            frame_bad   <= 1'b0;
            hcnt        <= '0;
            bus.h_total <= '0;
        end else begin
            if (le)
                line_cnt <= '0;
            else if (de_q && line_cnt != CMAX)
                line_cnt <= line_cnt + 1'b1;
            if (fs) begin
                frame_w   <= '0;
                frame_h   <= '0;
                frame_bad <= 1'b0;
            end else begin
                if (le) begin
                    if (frame_h == '0)
                        frame_w <= line_cnt;
                    else if (line_cnt != frame_w)
                        frame_bad <= 1'b1;
                    if (frame_h == CMAX)
                        frame_bad <= 1'b1;
                    else
                        frame_h <= frame_h + 1'b1;
                end
                if (de_q && line_cnt == CMAX)
                    frame_bad <= 1'b1;
            end
            // counting from 1 at the edge makes the latched value equal the period
            hcnt <= ls ? CNT_W'(1) : (hcnt == CMAX ? hcnt : hcnt + 1'b1);
            if (ls)
                bus.h_total <= hcnt;
        end
    end

    assign valid = !frame_bad && frame_w != '0 && frame_h != '0;
    assign match = valid && frame_w == cand_w && frame_h == cand_h;

    always_ff @(posedge clk)
        state <= rst ? SEARCH : state_n;

    always_comb begin
        state_n   = state;
        err_n     = 1'b0;
        take_cand = 1'b0;
        take_act  = 1'b0;
        if (fs) begin
            case (state)
                SEARCH: state_n = MEASURE;
                MEASURE: begin
                    take_cand = valid;
                    state_n   = valid ? VERIFY : MEASURE;
                end
                VERIFY: begin
                    err_n     = !match;
                    take_act  = match;
                    take_cand = !match && valid;
                    state_n   = match ? LOCKED : (valid ? VERIFY : MEASURE);
                end
                default: begin
                    err_n   = !match;
                    state_n = match ? LOCKED : MEASURE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cand_w         <= '0;
            cand_h         <= '0;
            bus.act_width  <= '0;
            bus.act_height <= '0;
            bus.locked     <= 1'b0;
            bus.err_pulse  <= 1'b0;
        end else begin
            if (take_cand) begin
                cand_w <= frame_w;
                cand_h <= frame_h;
            end
            if (take_act) begin
                bus.act_width  <= cand_w;
                bus.act_height <= cand_h;
            end
            bus.locked    <= state_n == LOCKED;
            bus.err_pulse <= err_n;
        end
    end

    // the frame opened by this FS writes only if that same FS leaves the FSM locked
    assign en       = fs ? state_n == LOCKED : frame_en;
    assign full_eff = fs ? 1'b0 : full;
    assign nxt_eff  = fs ? '0 : nxt;
    assign wr       = en && de_q && !full_eff;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_en      <= 1'b0;
            full          <= 1'b0;
            nxt           <= '0;
            bus.pix_valid <= 1'b0;
            bus.pix_sof   <= 1'b0;
            bus.pix_addr  <= '0;
            bus.pix_data  <= '0;
        end else begin
            frame_en      <= en;
            bus.pix_valid <= wr;
            bus.pix_sof   <= wr && nxt_eff == '0;
            bus.pix_data  <= rgb_q;
            if (wr) begin
                bus.pix_addr <= nxt_eff;
                nxt          <= nxt_eff + 1'b1;
                full         <= nxt_eff == AMAX;
            end else begin
                nxt  <= nxt_eff;
                full <= full_eff;
            end
        end
    end
endmodule

// File: tb/tb_lcd_rx_capture.sv
// tb_lcd_rx_capture: random video frames checked against a frame-level reference model on three configurations
module tb_lcd_rx_capture;
    localparam int S = 0, M = 1, V = 2, L = 3;

    typedef struct packed {
        logic        pv;
        logic [16:0] pa;
        logic [23:0] pd;
        logic        ps;
        logic [11:0] aw;
        logic [11:0] ah;
        logic [11:0] ht;
        logic        lk;
        logic        er;
    } obs_t;

    typedef struct {
        int          addr;
        logic [23:0] data;
        bit          sof;
    } pix_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lcd_rx_capture_if #(.CNT_W(12), .ADDR_W(17)) if0 ();
    lcd_rx_capture_if #(.CNT_W(12), .ADDR_W(4))  if1 ();
    lcd_rx_capture_if #(.CNT_W(12), .ADDR_W(17)) if2 ();

    lcd_rx_capture #(.HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(12), .ADDR_W(17)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
    lcd_rx_capture #(.HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(12), .ADDR_W(4))  u1 (.clk(clk), .rst(rst), .bus(if1.slave));
    lcd_rx_capture #(.HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(12), .ADDR_W(17)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));

    obs_t ob [3];
    assign ob[0] = '{if0.pix_valid, 17'(if0.pix_addr), if0.pix_data, if0.pix_sof, if0.act_width, if0.act_height, if0.h_total, if0.locked, if0.err_pulse};
    assign ob[1] = '{if1.pix_valid, 17'(if1.pix_addr), if1.pix_data, if1.pix_sof, if1.act_width, if1.act_height, if1.h_total, if1.locked, if1.err_pulse};
    assign ob[2] = '{if2.pix_valid, 17'(if2.pix_addr), if2.pix_data, if2.pix_sof, if2.act_width, if2.act_height, if2.h_total, if2.locked, if2.err_pulse};

    int n_chk = 0, n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    int   ms, cw, ch, aw_m, ah_m, hv, last_hp, ne_m;
    bit   en_m, exp_err;
    int   cnt [3];
    int   ne [3] = '{0, 0, 0};
    int   lines [$];
    pix_t q [3][$];
    pix_t e;

    function automatic int lim(input int d);
        return d == 1 ? 16 : 131072;
    endfunction

    task automatic model_reset();
        ms = S; cw = 0; ch = 0; aw_m = 0; ah_m = 0;
        en_m = 0; hv = 0; last_hp = 0;
        lines.delete();
        for (int d = 0; d < 3; d++) cnt[d] = 0;
    endtask

    // frame geometry comes from the list of completed line lengths since the last frame start
    task automatic fs_model();
        int w, h;
        bit bad, ok, same;
        h = lines.size();
        w = h > 0 ? lines[0] : 0;
        bad = 0;
        foreach (lines[i]) if (lines[i] != w) bad = 1;
        ok = !bad && w > 0 && h > 0;
        same = ok && w == cw && h == ch;
        exp_err = (ms == V || ms == L) && !same;
        if (exp_err) ne_m++;
        if (ms == S) ms = M;
        else if (ms == M) begin
            if (ok) begin cw = w; ch = h; ms = V; end
        end else if (same) begin
            if (ms == V) begin aw_m = cw; ah_m = ch; end
            ms = L;
        end else if (ms == V && ok) begin
            cw = w; ch = h;
        end else ms = M;
        lines.delete();
        en_m = ms == L;
        for (int d = 0; d < 3; d++) cnt[d] = 0;
    endtask

    task automatic drive(input bit h, input bit v, input bit d, input logic [23:0] p);
        if0.hs = ~h; if0.vs = ~v; if1.hs = ~h; if1.vs = ~v; if2.hs = h; if2.vs = v;
        if0.de = d; if1.de = d; if2.de = d;
        {if0.rgb_r, if0.rgb_g, if0.rgb_b} = p;
        {if1.rgb_r, if1.rgb_g, if1.rgb_b} = p;
        {if2.rgb_r, if2.rgb_g, if2.rgb_b} = p;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 0, '0);
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_outputs%0d", d), $countones(ob[d]), 0);
            check($sformatf("rst_pending%0d", d), q[d].size(), 0);
            q[d].delete();
        end
        model_reset();
    endtask

    task automatic line(input bit vsa, input int len, input int hp, input bit first, input bit pl);
        logic [23:0] px;
        bit          act;
        pix_t        p;
        for (int c = 0; c < hp; c++) begin
            @(negedge clk);
            if (first) begin
                for (int d = 0; d < 3; d++) begin
                    if (c == 1) begin
                        check($sformatf("lock_pre%0d", d), ob[d].lk, pl);
                        check($sformatf("err_pre%0d", d), ob[d].er, 0);
                    end
                    if (c == 2) begin
                        check($sformatf("lock%0d", d), ob[d].lk, ms == L);
                        check($sformatf("err%0d", d), ob[d].er, exp_err);
                        check($sformatf("act_w%0d", d), ob[d].aw, aw_m);
                        check($sformatf("act_h%0d", d), ob[d].ah, ah_m);
                        if (hv >= 1) check($sformatf("h_total%0d", d), ob[d].ht, last_hp);
                    end
                    if (c == 3) check($sformatf("err_post%0d", d), ob[d].er, 0);
                end
            end
            act = c >= 3 && c < 3 + len;
            px = 24'($urandom);
            drive(c < 2, vsa, act, px);
            if (act && en_m) begin
                for (int d = 0; d < 3; d++) begin
                    if (cnt[d] < lim(d)) begin
                        p.addr = cnt[d]; p.data = px; p.sof = cnt[d] == 0;
                        q[d].push_back(p);
                    end
                    cnt[d]++;
                end
            end
        end
        if (len > 0) lines.push_back(len);
        hv++;
        last_hp = hp;
    endtask

    task automatic frame(input int w, input int h, input int hp, input int short_ln, input int rst_ln);
        bit pl;
        pl = ms == L;
        fs_model();
        for (int l = 0; l < h + 4; l++) begin
            if (l == rst_ln) do_reset();
            line(l < 2, (l >= 3 && l < h + 3) ? w - ((l - 3 == short_ln) ? 1 : 0) : 0, hp, l == 0, pl);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (ob[d].er) ne[d]++;
            if (ob[d].pv) begin
                check($sformatf("pix_expected%0d", d), q[d].size() != 0, 1);
                if (q[d].size() != 0) begin
                    e = q[d].pop_front();
                    check($sformatf("pix_addr%0d", d), ob[d].pa, e.addr);
                    check($sformatf("pix_data%0d", d), ob[d].pd, e.data);
                    check($sformatf("pix_sof%0d", d), ob[d].ps, e.sof);
                end
            end
        end
    end

    initial begin
        int rw, rh;
        rst = 1'b1;
        ne_m = 0;
        drive(0, 0, 0, '0);
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();
        repeat (2) line(0, 0, 12, 0, 0);
        // clean 8x4 stream, lock on the third frame start
        repeat (4) frame(8, 4, 12, -1, -1);
        // one short line while locked, then relock
        frame(8, 4, 12, 2, -1);
        repeat (4) frame(8, 4, 12, -1, -1);
        // reset mid-frame while locked
        frame(8, 4, 12, -1, 5);
        repeat (4) frame(8, 4, 12, -1, -1);
        // candidate replaced during verification
        frame(8, 4, 12, -1, 5);
        frame(8, 4, 12, -1, -1);
        repeat (4) frame(8, 5, 12, -1, -1);
        // random geometry, mostly repeating so lock is reached now and then
        rw = 5; rh = 3;
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                rw = int'($urandom_range(1, 10));
                rh = int'($urandom_range(0, 5));
            end
            frame(rw, rh, rw + 4 + int'($urandom_range(0, 3)),
                  $urandom_range(0, 5) == 0 ? int'($urandom_range(0, 4)) : -1, -1);
        end
        frame(8, 4, 12, -1, -1);
        repeat (6) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("pix_leftover%0d", d), q[d].size(), 0);
            check($sformatf("err_count%0d", d), ne[d], ne_m);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/lcd_rx_capture.md
# lcd_rx_capture

Receive-side counterpart to the LCD timing generator. It samples a parallel RGB video stream (hs, vs, de, 24-bit pixel) in the pixel clock domain and measures the active geometry and line period. It locks once two consecutive frames agree, then emits addressed pixel writes for a downstream frame buffer. It is used as the capture/loopback checker behind the LCD output path and as the front end of a camera/LCD-in path.

## Interface
Parameters:
- HS_POL, 0, active level of hs (0 = active-low, 1 = active-high)
- VS_POL, 0, active level of vs
- CNT_W, 12, width of all geometry counters
- ADDR_W, 17, width of pix_addr

Ports:
- clk  in  1  pixel clock; sole clock
- rst  in  1  synchronous, active-high reset
- hs  in  1  horizontal sync, polarity per HS_POL
- vs  in  1  vertical sync, polarity per VS_POL
- de  in  1  data enable, active-high
- rgb_r / rgb_g / rgb_b  in  8 each  pixel colour
- pix_valid  out  1  pixel write strobe
- pix_addr  out  ADDR_W  linear address, 0 = first active pixel of frame
- pix_data  out  24  {r,g,b}
- pix_sof  out  1  asserted with the frame's first pix_valid
- act_width  out  CNT_W  locked active pixels per line
- act_height  out  CNT_W  locked active lines per frame
- h_total  out  CNT_W  clocks between consecutive hs active edges, most recent
- locked  out  1  geometry stable
- err_pulse  out  1  one-cycle pulse when a locked or verifying frame mismatches

## Operation
- Inputs are registered once. Edge detection runs on the registered copies.
- A frame start (FS) is the first cycle the registered vs is at its active level after a cycle inactive. A line start is the equivalent event on hs. A line end (LE) is the falling edge of registered de.
- Per-frame measurement:
  - line_cnt counts de cycles and is cleared at LE.
  - At the first LE of a frame, frame_w = line_cnt. At any later LE where line_cnt ≠ frame_w, frame_bad is set.
  - frame_h counts LEs.
  - All three (frame_w, frame_bad, frame_h) clear at FS.
  - Counters saturate at 2^CNT_W−1, and saturation sets frame_bad.
- h_total: a free counter cleared at each hs active edge. Its pre-clear value is latched to h_total.
- FSM, evaluated at each FS for the frame just ended:
  - SEARCH: first FS → MEASURE. No data is checked.
  - MEASURE: if !frame_bad and frame_w≠0 and frame_h≠0, latch cand_w/cand_h and go to VERIFY; else stay.
  - VERIFY: match (!frame_bad, frame_w=cand_w, frame_h=cand_h) → LOCKED, act_width/act_height ← cand. Mismatch → err_pulse, new candidate latched, stay VERIFY (or MEASURE if the frame is invalid).
  - LOCKED: match → stay. Mismatch → err_pulse, locked=0, MEASURE.
- locked = (state==LOCKED), registered.
- Pixel path, active only when locked is already 1 at FS:
  - pix_valid = registered de for that frame.
  - pix_data = registered rgb.
  - pix_addr starts at 0 for the first pixel and increments after each pix_valid.
  - Once pix_addr = 2^ADDR_W−1 has been written, pix_valid is suppressed until the next FS; the address holds.
  - A frame during which lock is lost still completes its writes. The FSM only moves at FS, so lock cannot drop mid-frame.

## Timing
- Reset: all outputs 0; state SEARCH; all counters 0.
- Latency: input → pix_valid/pix_data/pix_addr is 2 cycles (input register + output register).
- pix_sof is coincident with the first pix_valid of a frame only.
- The FSM transition, err_pulse and locked update occur 2 cycles after the vs edge at the pins.
- de active with vs simultaneously asserting: the FS is processed first, and that pixel belongs to the new frame with address 0.
- vs edge with no de in the preceding frame: frame_w=0, treated as a mismatch or invalid frame.
- Reset asserted mid-frame: everything clears the next cycle; the next FS is treated as the first FS (SEARCH).
- The earliest lock is at the 3rd FS. The first writes happen in the frame that follows that FS.

## Test plan
- 8×4 active, hs period 12, 3 frames: locked rises at the 3rd FS (+2 cycles). Frame 3 produces 32 pix_valid with addr 0..31, pix_sof on addr 0. act_width=8, act_height=4, h_total=12.
- Locked at 8×4, then one frame with a 7-pixel line: err_pulse once at the following FS, locked=0. Relock 2 frames later, with no writes in the intervening frames.
- Frame of 8×5 during VERIFY on 8×4: err_pulse, candidate becomes 8×5. The next 8×5 frame locks with act_height=5.
- ADDR_W=4 with an 8×4 locked stream: addr 0..15 written, remaining 16 pixels suppressed. The next frame restarts at 0.
- rst pulsed mid-frame while locked: outputs 0 next cycle, and lock reacquired after 3 FS.
- VS_POL=1, HS_POL=1 with inverted syncs: results identical to the first scenario.
